// File: rtl/pll_reconfig_seq.sv
// Avalon-MM write sequencer that retunes a reconfigurable PLL whenever the debounced clock mode changes.
// Optional feature macro PLL_RECFG_CCNT_EN: adds the C0 counter write (addr 5) between the K and start writes.
module pll_reconfig_seq #(
  parameter int NUM_MODES     = 4,
  parameter int MODE_W        = 2,
  parameter int RESET_MODE    = 0,
  parameter int STABLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 3,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MODE_W-1:0]       mode_sel,
  input  logic [NUM_MODES*32-1:0] mode_k,
  input  logic [NUM_MODES*32-1:0] mode_c,
  input  logic                    pll_locked,
  input  logic                    mgmt_waitrequest,
  output logic                    mgmt_write,
  output logic [5:0]              mgmt_address,
  output logic [31:0]             mgmt_writedata,
  output logic                    busy,
  output logic                    done,
  output logic                    lock_err,
  output logic [MODE_W-1:0]       applied_mode
);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(RESET_MODE);
  localparam logic [5:0] ADDR_MODE = 6'd0, ADDR_START = 6'd2, ADDR_C = 6'd5, ADDR_K = 6'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_GAP_MODE, S_WR_K, S_GAP_K, S_WR_C, S_GAP_C,
    S_WR_START, S_LOCK_DROP, S_LOCK_RISE
  } state_t;

  logic [31:0] k_word [NUM_MODES];
`ifdef PLL_RECFG_CCNT_EN
  logic [31:0] c_word [NUM_MODES];
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_unpack
    assign k_word[m] = mode_k[32*m +: 32];
    assign c_word[m] = mode_c[32*m +: 32];
  end
`else
  logic unused_mode_c;
  assign unused_mode_c = ^mode_c;
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_unpack
    assign k_word[m] = mode_k[32*m +: 32];
  end
`endif

  logic [MODE_W-1:0] mode_s1_q, mode_s2_q;
  logic              lock_s1_q, lock_s2_q;

  // NOTE: synchronous reset of the synchroniser flops is deliberate; it keeps the whole block on one reset style.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      mode_s1_q <= mode_sel;
      mode_s2_q <= mode_s1_q;
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  // Debounce: a candidate becomes the accepted mode after STABLE_CYCLES equal samples.
  logic [MODE_W-1:0] cand_q, cand_d, acc_q, acc_d;
  logic [STAB_W-1:0] stab_q, stab_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    acc_d  = acc_q;
    if (mode_s2_q != cand_q) begin
      cand_d = mode_s2_q;
      stab_d = STAB_W'(1);
    end else if (stab_q != STAB_DONE) begin
      stab_d = stab_q + 1'b1;
    end
    if (mode_s2_q == cand_q && stab_d == STAB_DONE) acc_d = cand_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= MODE_RST;
      stab_q <= '0;
      acc_q  <= MODE_RST;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
      acc_q  <= acc_d;
    end
  end

  state_t            state_q, state_d;
  logic [MODE_W-1:0] target_q, target_d, applied_q, applied_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              busy_q, busy_d, done_q, done_d, lock_err_q, lock_err_d;
  logic              pending_q, pending_d;
  logic              wr_accept;

  assign wr_accept = !mgmt_waitrequest;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    applied_d      = applied_q;
    gap_d          = gap_q;
    tmr_d          = tmr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    lock_err_d     = lock_err_q;
    pending_d      = pending_q;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    // A change seen mid-sequence is remembered; IDLE re-evaluates it on return.
    if (state_q != S_IDLE && acc_q != target_q) pending_d = 1'b1;
    case (state_q)
      S_IDLE: if (pending_q || acc_q != applied_q) begin
        pending_d = 1'b0;
        if (acc_q != applied_q) begin
          state_d  = S_WR_MODE;
          target_d = acc_q;
          busy_d   = 1'b1;
        end
      end
      S_WR_MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_MODE;
        if (wr_accept) begin state_d = S_GAP_MODE; gap_d = '0; end
      end
      S_GAP_MODE: if (gap_q == GAP_LAST) state_d = S_WR_K; else gap_d = gap_q + 1'b1;
      S_WR_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_K;
        mgmt_writedata = k_word[target_q];
        if (wr_accept) begin state_d = S_GAP_K; gap_d = '0; end
      end
`ifdef PLL_RECFG_CCNT_EN
      S_GAP_K: if (gap_q == GAP_LAST) state_d = S_WR_C; else gap_d = gap_q + 1'b1;
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_C;
        mgmt_writedata = c_word[target_q];
        if (wr_accept) begin state_d = S_GAP_C; gap_d = '0; end
      end
      S_GAP_C: if (gap_q == GAP_LAST) state_d = S_WR_START; else gap_d = gap_q + 1'b1;
`else
      S_GAP_K: if (gap_q == GAP_LAST) state_d = S_WR_START; else gap_d = gap_q + 1'b1;
`endif
      S_WR_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_START;
        if (wr_accept) begin
          state_d   = S_LOCK_DROP;
          applied_d = target_q;
          tmr_d     = '0;
        end
      end
      // Lock that never drops within the window counts as already relocked.
      S_LOCK_DROP: begin
        if (!lock_s2_q) begin
          state_d = S_LOCK_RISE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE; done_d = 1'b1; lock_err_d = 1'b0; busy_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LOCK_RISE: begin
        if (lock_s2_q) begin
          state_d = S_IDLE; done_d = 1'b1; lock_err_d = 1'b0; busy_d = 1'b0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE; lock_err_d = 1'b1; busy_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= MODE_RST;
      applied_q  <= MODE_RST;
      gap_q      <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lock_err_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      applied_q  <= applied_d;
      gap_q      <= gap_d;
      tmr_q      <= tmr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lock_err_q <= lock_err_d;
      pending_q  <= pending_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign lock_err     = lock_err_q;
  assign applied_mode = applied_q;
endmodule
